// File: rtl/frac_clk_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frac_clk_div_pkg - shared types, reset configuration and legality check
// for the frac_clk_div_mc fractional clock divider.            Rev 1.0
// ---------------------------------------------------------------------------
package frac_clk_div_pkg;

  localparam int CFG_ACC_W = 16;
  localparam int RST_INC   = 1;
  localparam int RST_MOD   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [CFG_ACC_W-1:0] inc;
    logic [CFG_ACC_W-1:0] mod;
  } div_cfg_t;

  // Operands arrive zero-extended to 32 bits so any ACC_W up to 32 can share this.
  function automatic logic cfg_legal(input logic [31:0] inc, input logic [31:0] mod);
    return (inc != 32'd0) && (mod != 32'd0) && ({inc, 1'b0} <= {1'b0, mod});
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_clk_div_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frac_clk_div_ch - one divider channel: FSM, phase accumulator, shadow
// config and busy flag. Optional edge counter: FRAC_CLK_DIV_EDGE_CNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module frac_clk_div_ch #(
  parameter int ACC_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_mod,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_busy
`ifdef FRAC_CLK_DIV_EDGE_CNT_EN
  ,
  output logic [15:0]      o_edge_cnt
`endif
);
  import frac_clk_div_pkg::*;

  typedef struct packed {
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] mod;
  } ch_cfg_t;

  localparam ch_cfg_t c_rst_cfg = '{inc: ACC_W'(RST_INC), mod: ACC_W'(RST_MOD)};

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic             r_en;
  logic [ACC_W-1:0] r_acc;
  logic             r_clk;
  logic             r_rise;
  logic             r_busy;
  ch_cfg_t          r_act;
  ch_cfg_t          r_shd;

  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_diff;
  logic             w_wrap;
  logic             w_accum;
  logic             w_tog;
  logic             w_apply;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping the enable while high finishes the high phase in STOP (no runt pulse).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_en) w_state_nxt = RUN;
      RUN: begin
        if (!r_en) w_state_nxt = (!r_clk || w_tog) ? IDLE : STOP;
      end
      STOP: begin
        if (r_en)       w_state_nxt = RUN;
        else if (w_tog) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Legal configs keep sum below 2*MOD, so one conditional subtract suffices.
  always_comb begin
    w_sum   = {1'b0, r_acc} + {r_act.inc, 1'b0};
    w_diff  = w_sum[ACC_W-1:0] - r_act.mod;
    w_wrap  = (w_sum >= {1'b0, r_act.mod});
    w_accum = (r_state == STOP) || ((r_state == RUN) && (r_en || r_clk));
    w_tog   = w_accum && w_wrap;
    w_apply = r_busy && ((r_state == IDLE) || (w_tog && !r_clk));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_acc  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_busy <= 1'b0;
      r_act  <= c_rst_cfg;
      r_shd  <= c_rst_cfg;
    end else begin
      r_en   <= i_en;
      r_clk  <= w_tog ? !r_clk : r_clk;
      r_rise <= w_tog && !r_clk;
      // A new config restarts the phase exactly at the rising edge.
      if ((w_state_nxt == IDLE) || w_apply) begin
        r_acc <= '0;
      end else if (w_accum) begin
        r_acc <= w_wrap ? w_diff : w_sum[ACC_W-1:0];
      end
      if (w_apply) begin
        r_act  <= r_shd;
        r_busy <= 1'b0;
      end else if (i_wr) begin
        r_shd.inc <= i_inc;
        r_shd.mod <= i_mod;
        r_busy    <= 1'b1;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_rise = r_rise;
  assign o_busy = r_busy;

`ifdef FRAC_CLK_DIV_EDGE_CNT_EN
  logic [15:0] r_edge_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
    end else if (w_tog && !r_clk) begin
      r_edge_cnt <= r_edge_cnt + 16'd1;
    end
  end

  assign o_edge_cnt = r_edge_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/frac_clk_div_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frac_clk_div_mc - multi-channel programmable fractional clock divider top.
// Optional per-channel edge counters: FRAC_CLK_DIV_EDGE_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module frac_clk_div_mc #(
  parameter  int NUM_CH = 4,
  parameter  int ACC_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_mod,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] ch_busy
`ifdef FRAC_CLK_DIV_EDGE_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] edge_cnt
`endif
);
  import frac_clk_div_pkg::*;

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_wr;
  logic              w_ch_ok;
  logic              w_sel_busy;
  logic              w_accept;
  logic              w_legal;
  logic              r_err;

  // Out-of-range channel numbers are accepted and reported as illegal.
  always_comb begin
    w_ch_ok    = 1'b0;
    w_sel_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        w_ch_ok    = 1'b1;
        w_sel_busy = w_busy[i];
      end
    end
  end

  assign cfg_ready = !w_sel_busy;
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_legal   = w_ch_ok && cfg_legal(32'(cfg_inc), 32'(cfg_mod));

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = w_accept && w_legal && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
    end
  end

  assign cfg_err = r_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    frac_clk_div_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .i_en      (ch_en[g]),
      .i_wr      (w_wr[g]),
      .i_inc     (cfg_inc),
      .i_mod     (cfg_mod),
      .o_clk     (clk_out[g]),
      .o_rise    (rise_pulse[g]),
      .o_busy    (w_busy[g])
`ifdef FRAC_CLK_DIV_EDGE_CNT_EN
      ,
      .o_edge_cnt(edge_cnt[g*16 +: 16])
`endif
    );
  end

  assign ch_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_frac_clk_div_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frac_clk_div_mc - directed self-checking bench for frac_clk_div_mc.
// ---------------------------------------------------------------------------
module tb_frac_clk_div_mc;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 16;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_mod;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] ch_busy;
`ifdef FRAC_CLK_DIV_EDGE_CNT_EN
  logic [NUM_CH*16-1:0] edge_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  frac_clk_div_mc #(
    .NUM_CH(NUM_CH),
    .ACC_W (ACC_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_mod   (cfg_mod),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .rise_pulse(rise_pulse),
    .ch_busy   (ch_busy)
`ifdef FRAC_CLK_DIV_EDGE_CNT_EN
    ,
    .edge_cnt  (edge_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int inc, input int md);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_inc   = ACC_W'(inc);
    cfg_mod   = ACC_W'(md);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int run;
    int bad;
    int phases;
    int found;
    int il_inc [3];
    int il_mod [3];
    logic [9:0] e_clk;
    logic [9:0] e_busy;
    logic [9:0] e_rise;

    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_inc   = '0;
    cfg_mod   = '0;
    repeat (3) tick();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_rise", 32'(rise_pulse), 0);
    chk("rst_busy", 32'(ch_busy), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;

    // Default config on ch0: toggles every cycle
    ch_en = 4'b0001;
    tick();
    tick();
    chk("t1_pre_rise", 32'(clk_out[0]), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t1_clk", 32'(clk_out[0]), 32'(k % 2 == 0));
      chk("t1_rise", 32'(rise_pulse[0]), 32'(k % 2 == 0));
    end

    // ch1 INC=1 MOD=4 while idle
    cfg(1, 1, 4);
    #1;
    chk("t2_ready", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    chk("t2_busy_set", 32'(ch_busy), 32'h2);
    chk("t2_err", 32'(cfg_err), 0);
    #1;
    chk("t2_ready_low", 32'(cfg_ready), 0);
    tick();
    chk("t2_busy_clr", 32'(ch_busy), 0);
    ch_en = 4'b0011;
    repeat (3) tick();
    chk("t2_pre_rise", 32'(clk_out[1]), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_clk", 32'(clk_out[1]), 32'((k % 4) < 2));
      chk("t2_rise", 32'(rise_pulse[1]), 32'((k % 4) == 0));
    end

    // ch2 INC=3 MOD=10: 3 rises per 10 cycles
    cfg(2, 3, 10);
    tick();
    cfg_valid = 1'b0;
    chk("t3_busy_set", 32'(ch_busy), 32'h4);
    tick();
    chk("t3_busy_clr", 32'(ch_busy), 0);
    ch_en = 4'b0111;
    repeat (3) tick();
    chk("t3_pre_rise", 32'(clk_out[2]), 0);
    tick();
    chk("t3_first_rise", 32'(rise_pulse[2]), 1);
    cnt = 0; run = 1; bad = 0; phases = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (rise_pulse[2]) cnt++;
      if (clk_out[2]) begin
        run++;
      end else if (run != 0) begin
        phases++;
        if (run > 2) bad++;
        run = 0;
      end
    end
    chk("t3_rises_300pm1", 32'(cnt >= 299 && cnt <= 301), 1);
    chk("t3_high_len", 32'(bad), 0);
    chk("t3_phases", 32'(phases >= 299), 1);

    // Illegal configs on ch2 are rejected and leave the rate alone
    il_inc[0] = 6; il_mod[0] = 10;
    il_inc[1] = 0; il_mod[1] = 5;
    il_inc[2] = 3; il_mod[2] = 0;
    for (int k = 0; k < 3; k++) begin
      cfg(2, il_inc[k], il_mod[k]);
      #1;
      chk("t4_ready", 32'(cfg_ready), 1);
      tick();
      cfg_valid = 1'b0;
      chk("t4_err", 32'(cfg_err), 1);
      chk("t4_busy", 32'(ch_busy), 0);
      tick();
      chk("t4_err_pulse", 32'(cfg_err), 0);
    end
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rise_pulse[2]) cnt++;
    end
    chk("t4_rate", 32'(cnt), 30);

    // Boundary legal config 2*INC == MOD on ch3
    cfg(3, 5, 10);
    tick();
    cfg_valid = 1'b0;
    chk("t4b_err", 32'(cfg_err), 0);
    chk("t4b_busy", 32'(ch_busy), 32'h8);
    tick();
    chk("t4b_busy_clr", 32'(ch_busy), 0);
    ch_en = 4'b1111;
    repeat (3) tick();
    chk("t4b_rise", 32'(rise_pulse[3]), 1);
    tick();
    chk("t4b_fall", 32'(clk_out[3]), 0);

    // ch0 to MOD=8 (applied at next rise)
    cfg(0, 1, 8);
    tick();
    cfg_valid = 1'b0;
    chk("t5a_busy", 32'(ch_busy[0]), 1);
    found = 0;
    for (int k = 0; k < 4 && found == 0; k++) begin
      tick();
      if (!ch_busy[0]) found = 1;
    end
    chk("t5a_applied", 32'(found), 1);
    chk("t5a_rise", 32'(rise_pulse[0]), 1);
    tick();
    chk("t5_high", 32'(clk_out[0]), 1);
    // Mid-high-phase update to MOD=2
    cfg(0, 1, 2);
    #1;
    chk("t5_ready", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    e_clk  = 10'b0101000011;
    e_busy = 10'b0000111111;
    e_rise = 10'b0101000000;
    for (int k = 0; k < 10; k++) begin
      chk("t5_clk", 32'(clk_out[0]), 32'(e_clk[k]));
      chk("t5_busy", 32'(ch_busy[0]), 32'(e_busy[k]));
      chk("t5_ready_seq", 32'(cfg_ready), 32'(!e_busy[k]));
      chk("t5_rise", 32'(rise_pulse[0]), 32'(e_rise[k]));
      tick();
    end

    // Enable drop while high on MOD=8
    cfg(0, 1, 8);
    tick();
    cfg_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 4 && found == 0; k++) begin
      tick();
      if (!ch_busy[0]) found = 1;
    end
    chk("t6_applied", 32'(found), 1);
    chk("t6_rise", 32'(rise_pulse[0]), 1);
    ch_en = 4'b1110;
    for (int k = 1; k < 12; k++) begin
      tick();
      chk("t6_clk", 32'(clk_out[0]), 32'(k <= 3));
      chk("t6_rise_off", 32'(rise_pulse[0]), 0);
    end

    // Asynchronous reset with a pending config on ch2
    cfg(2, 1, 10);
    tick();
    cfg_valid = 1'b0;
    chk("t7_busy_pre", 32'(ch_busy), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_clk", 32'(clk_out), 0);
    chk("t7_async_busy", 32'(ch_busy), 0);
    chk("t7_async_rise", 32'(rise_pulse), 0);
    tick();
    rst_n = 1'b1;
    ch_en = 4'b0100;
    repeat (3) tick();
    chk("t7_def_rise", 32'(rise_pulse[2]), 1);
    tick();
    chk("t7_def_fall", 32'(clk_out[2]), 0);
    tick();
    chk("t7_def_rise2", 32'(clk_out[2]), 1);
    chk("t7_busy_post", 32'(ch_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
